gobang_game_ctrl: RTL and testbench

//  Game-state controller for the 15x15 gobang board. Consumes decoded keyboard

---
 rtl/gobang_pkg.sv | 50 +++++
 rtl/gobang_if.sv | 8 +
 rtl/gobang_probe.sv | 35 +++
 rtl/gobang_game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_gobang_game_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gobang_pkg.sv
// Shared constants, command/winner encodings, FSM states and board helpers
// for the gobang game controller.
package gobang_pkg;

  localparam int N       = 15;
  localparam int CELLS   = N * N;
  localparam int CENTER  = 7;
  localparam int WIN_LEN = 5;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_UP      = 3'd1;
  localparam logic [2:0] CMD_DOWN    = 3'd2;
  localparam logic [2:0] CMD_LEFT    = 3'd3;
  localparam logic [2:0] CMD_RIGHT   = 3'd4;
  localparam logic [2:0] CMD_PLACE   = 3'd5;
  localparam logic [2:0] CMD_RESTART = 3'd6;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_BLACK = 2'b01;
  localparam logic [1:0] WINNER_WHITE = 2'b10;
  localparam logic [1:0] WINNER_DRAW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } delta_t;

  // d0 horizontal, d1 vertical, d2 diagonal, d3 anti-diagonal
  function automatic delta_t dir_delta(input logic [1:0] dir);
    delta_t d;
    case (dir)
      2'd0:    begin d.dr = 2'sd0; d.dc = 2'sd1;  end
      2'd1:    begin d.dr = 2'sd1; d.dc = 2'sd0;  end
      2'd2:    begin d.dr = 2'sd1; d.dc = 2'sd1;  end
      default: begin d.dr = 2'sd1; d.dc = -2'sd1; end
    endcase
    return d;
  endfunction

  function automatic logic [7:0] idx(input logic [3:0] row, input logic [3:0] col);
    return 8'(row) * 8'(N) + 8'(col);
  endfunction

endpackage

// File: rtl/gobang_if.sv
// Decoded keyboard command channel from the PS2 front end.
interface gobang_if;
  logic       cmd_valid;
  logic [2:0] cmd;

  modport master (output cmd_valid, output cmd);
  modport slave  (input  cmd_valid, input  cmd);
endinterface

// File: rtl/gobang_probe.sv
// Combinational probe address: anchor + k*side*dir, with board bounds test.
module gobang_probe
  import gobang_pkg::*;
(
  input  logic [3:0] anchor_row,
  input  logic [3:0] anchor_col,
  input  logic [1:0] dir,
  input  logic       side,
  input  logic [2:0] k,
  output logic [7:0] probe_idx,
  output logic       in_bounds
);

  localparam logic signed [4:0] MAX_RC = 5'(N - 1);

  delta_t            d;
  logic signed [4:0] step_k;
  logic signed [4:0] dr5;
  logic signed [4:0] dc5;
  logic signed [4:0] pr;
  logic signed [4:0] pc;

  // Off-board coordinates (up to 18) wrap negative in 5 bits, so the sign test catches them.
  always_comb begin
    d         = dir_delta(dir);
    dr5       = {{3{d.dr[1]}}, d.dr};
    dc5       = {{3{d.dc[1]}}, d.dc};
    step_k    = side ? -$signed({2'b00, k}) : $signed({2'b00, k});
    pr        = $signed({1'b0, anchor_row}) + step_k * dr5;
    pc        = $signed({1'b0, anchor_col}) + step_k * dc5;
    in_bounds = (pr >= 5'sd0) && (pr <= MAX_RC) && (pc >= 5'sd0) && (pc <= MAX_RC);
    probe_idx = idx(pr[3:0], pc[3:0]);
  end

endmodule

// File: rtl/gobang_game_ctrl.sv
// Gobang game state: cursor, stone bitmaps, turn order and a one-probe-per-cycle
// five-in-a-row search around the last placed stone.
module gobang_game_ctrl
  import gobang_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  gobang_if.slave          cmd_if,
  output logic [CELLS-1:0] display_black,
  output logic [CELLS-1:0] display_white,
  output logic [3:0]       choose_row,
  output logic [3:0]       choose_col,
  output logic             turn,
  output logic             busy,
  output logic             reject,
  output logic             game_over,
  output logic [1:0]       winner
);

  localparam logic [2:0] K_LAST  = 3'd4;
  localparam logic [2:0] RUN_WIN = 3'(WIN_LEN - 1);
  localparam logic [3:0] EDGE    = 4'(N - 1);

  state_t     state_q, state_d;
  logic [3:0] anchor_row, anchor_col;
  logic [1:0] dir;
  logic       side;
  logic [2:0] k, run, run_inc;
  logic [7:0] count;
  logic       win_q;
  logic [7:0] cur_idx, probe_idx;
  logic       probe_in, occupied, hit, side_end, win_hit;
  logic       cmd_restart, idle_cmd;

  gobang_probe u_probe (
    .anchor_row (anchor_row),
    .anchor_col (anchor_col),
    .dir        (dir),
    .side       (side),
    .k          (k),
    .probe_idx  (probe_idx),
    .in_bounds  (probe_in)
  );

  always_comb begin
    cur_idx     = idx(choose_row, choose_col);
    occupied    = display_black[cur_idx] | display_white[cur_idx];
    hit         = probe_in && (turn ? display_white[probe_idx] : display_black[probe_idx]);
    run_inc     = run + 3'd1;
    win_hit     = hit && (run_inc >= RUN_WIN);
    side_end    = !hit || (k == K_LAST);
    cmd_restart = cmd_if.cmd_valid && (cmd_if.cmd == CMD_RESTART);
    idle_cmd    = cmd_if.cmd_valid && (state_q == ST_IDLE) && !game_over;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cmd_restart) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (idle_cmd && cmd_if.cmd == CMD_PLACE && !occupied) state_d = ST_CHECK;
        ST_CHECK: if (win_hit || (side_end && side && dir == 2'd3)) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || cmd_restart) begin
      display_black <= '0;
      display_white <= '0;
      choose_row    <= 4'(CENTER);
      choose_col    <= 4'(CENTER);
      turn          <= 1'b0;
      reject        <= 1'b0;
      game_over     <= 1'b0;
      winner        <= WINNER_NONE;
      count         <= 8'd0;
      win_q         <= 1'b0;
      anchor_row    <= 4'd0;
      anchor_col    <= 4'd0;
      dir           <= 2'd0;
      side          <= 1'b0;
      k             <= 3'd1;
      run           <= 3'd0;
    end else begin
      reject <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (idle_cmd) begin
            case (cmd_if.cmd)
              CMD_UP:    choose_row <= (choose_row == 4'd0) ? EDGE : choose_row - 4'd1;
              CMD_DOWN:  choose_row <= (choose_row == EDGE) ? 4'd0 : choose_row + 4'd1;
              CMD_LEFT:  choose_col <= (choose_col == 4'd0) ? EDGE : choose_col - 4'd1;
              CMD_RIGHT: choose_col <= (choose_col == EDGE) ? 4'd0 : choose_col + 4'd1;
              CMD_PLACE: begin
                if (occupied) begin
                  reject <= 1'b1;
                end else begin
                  if (turn) display_white[cur_idx] <= 1'b1;
                  else      display_black[cur_idx] <= 1'b1;
                  count      <= count + 8'd1;
                  anchor_row <= choose_row;
                  anchor_col <= choose_col;
                  dir        <= 2'd0;
                  side       <= 1'b0;
                  k          <= 3'd1;
                  run        <= 3'd0;
                  win_q      <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        ST_CHECK: begin
          // run accumulates across both sides of a direction and restarts per direction
          if (win_hit) begin
            win_q <= 1'b1;
          end else if (side_end) begin
            k <= 3'd1;
            if (hit) run <= run_inc;
            if (side) begin
              side <= 1'b0;
              dir  <= dir + 2'd1;
              run  <= 3'd0;
            end else begin
              side <= 1'b1;
            end
          end else begin
            run <= run_inc;
            k   <= k + 3'd1;
          end
        end
        ST_DONE: begin
          if (win_q) begin
            game_over <= 1'b1;
            winner    <= turn ? WINNER_WHITE : WINNER_BLACK;
          end else if (count == 8'(CELLS)) begin
            game_over <= 1'b1;
            winner    <= WINNER_DRAW;
          end else begin
            turn <= ~turn;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gobang_game_ctrl.sv
// Bench for gobang_game_ctrl: cursor vector table, hand-written game
// sequences and random commands checked against a board-level model.
module tb_gobang_game_ctrl;
  import gobang_pkg::*;

  typedef logic [CELLS-1:0] wide_t;
  typedef struct {
    logic [2:0] cmd;
    int         row;
    int         col;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  gobang_if cif();
  logic [CELLS-1:0] display_black, display_white;
  logic [3:0] choose_row, choose_col;
  logic turn, busy, reject, game_over;
  logic [1:0] winner;

  gobang_game_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_if        (cif),
    .display_black (display_black),
    .display_white (display_white),
    .choose_row    (choose_row),
    .choose_col    (choose_col),
    .turn          (turn),
    .busy          (busy),
    .reject        (reject),
    .game_over     (game_over),
    .winner        (winner)
  );

  always #5 clk = ~clk;

  wide_t m_black, m_white;
  int m_row, m_col, m_count;
  logic m_turn, m_over;
  logic [1:0] m_winner;
  int checks = 0;
  int errors = 0;
  vec_t tbl[20];
  int bl_r[$], bl_c[$], wh_r[$], wh_c[$];

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_black = '0; m_white = '0;
    m_row = CENTER; m_col = CENTER; m_count = 0;
    m_turn = 1'b0; m_over = 1'b0; m_winner = 2'b00;
  endtask

  function automatic int dr_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int dc_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
  endfunction

  // 0 empty or off-board, 1 black, 2 white
  function automatic int colour_at(input int r, input int c);
    if (r < 0 || r >= N || c < 0 || c >= N) return 0;
    if (m_black[r*N + c]) return 1;
    if (m_white[r*N + c]) return 2;
    return 0;
  endfunction

  function automatic bit has_five(input int r, input int c, input int col);
    int cnt, rr, cc;
    for (int d = 0; d < 4; d++) begin
      cnt = 1;
      for (int s = -1; s <= 1; s += 2) begin
        rr = r + s*dr_of(d);
        cc = c + s*dc_of(d);
        while (colour_at(rr, cc) == col) begin
          cnt++;
          rr += s*dr_of(d);
          cc += s*dc_of(d);
        end
      end
      if (cnt >= WIN_LEN) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Number of probe cycles the search needs around (r,c)
  function automatic int probe_cycles(input int r, input int c, input int col);
    int n, run, rr, cc, m;
    n = 0;
    for (int d = 0; d < 4; d++) begin
      run = 0;
      for (int s = 0; s < 2; s++) begin
        for (int k = 1; k <= 4; k++) begin
          m  = (s == 0) ? k : -k;
          rr = r + m*dr_of(d);
          cc = c + m*dc_of(d);
          n++;
          if (colour_at(rr, cc) != col) break;
          run++;
          if (run + 1 >= WIN_LEN) return n;
        end
      end
    end
    return n;
  endfunction

  task automatic do_cmd(input logic [2:0] c);
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd       = c;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    cif.cmd       = CMD_NOP;
  endtask

  task automatic chk_state(input string nm);
    chk({nm, " row"},    wide_t'(choose_row), wide_t'(m_row));
    chk({nm, " col"},    wide_t'(choose_col), wide_t'(m_col));
    chk({nm, " black"},  display_black, m_black);
    chk({nm, " white"},  display_white, m_white);
    chk({nm, " turn"},   wide_t'(turn), wide_t'(m_turn));
    chk({nm, " over"},   wide_t'(game_over), wide_t'(m_over));
    chk({nm, " winner"}, wide_t'(winner), wide_t'(m_winner));
    chk({nm, " busy"},   wide_t'(busy), wide_t'(1'b0));
    chk({nm, " reject"}, wide_t'(reject), wide_t'(1'b0));
    chk({nm, " overlap"}, display_black & display_white, '0);
  endtask

  task automatic issue(input logic [2:0] c, input string nm);
    int i0, exp_n, n;
    bit win;
    do_cmd(c);
    if (c == CMD_RESTART) begin
      model_reset();
    end else if (!m_over) begin
      case (c)
        CMD_UP:    m_row = (m_row + N - 1) % N;
        CMD_DOWN:  m_row = (m_row + 1) % N;
        CMD_LEFT:  m_col = (m_col + N - 1) % N;
        CMD_RIGHT: m_col = (m_col + 1) % N;
        CMD_PLACE: begin
          i0 = m_row*N + m_col;
          if (m_black[i0] || m_white[i0]) begin
            chk({nm, " reject pulse"}, wide_t'(reject), wide_t'(1'b1));
            @(negedge clk);
          end else begin
            if (m_turn) m_white[i0] = 1'b1;
            else        m_black[i0] = 1'b1;
            m_count++;
            win   = has_five(m_row, m_col, m_turn ? 2 : 1);
            exp_n = probe_cycles(m_row, m_col, m_turn ? 2 : 1) + 1;
            chk({nm, " busy after place"}, wide_t'(busy), wide_t'(1'b1));
            chk({nm, " stone"}, wide_t'(m_turn ? display_white[i0] : display_black[i0]), wide_t'(1'b1));
            n = 1;
            while (n < 40) begin
              @(negedge clk);
              if (!busy) break;
              n++;
            end
            chk({nm, " busy cycles"}, wide_t'(n), wide_t'(exp_n));
            if (win) begin
              m_over = 1'b1; m_winner = m_turn ? 2'b10 : 2'b01;
            end else if (m_count == CELLS) begin
              m_over = 1'b1; m_winner = 2'b11;
            end else begin
              m_turn = ~m_turn;
            end
          end
        end
        default: ;
      endcase
    end
    chk_state(nm);
  endtask

  task automatic goto(input int r, input int c);
    for (int i = 0; i < N && m_row != r && !m_over; i++) issue(CMD_DOWN, "goto row");
    for (int i = 0; i < N && m_col != c && !m_over; i++) issue(CMD_RIGHT, "goto col");
  endtask

  task automatic place_at(input int r, input int c, input string nm);
    goto(r, c);
    issue(CMD_PLACE, nm);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t3r[9], t3c[9], t4r[10], t4c[10], ter[7], tec[7];
    int r;
    logic [2:0] rc;

    for (int i = 0; i < 8; i++) tbl[i] = '{CMD_UP, (i < 7) ? 6 - i : 14, 7};
    for (int i = 0; i < 8; i++) tbl[8+i] = '{CMD_LEFT, 14, (i < 7) ? 6 - i : 14};
    tbl[16] = '{CMD_DOWN, 0, 14};
    tbl[17] = '{CMD_RIGHT, 0, 0};
    tbl[18] = '{CMD_NOP, 0, 0};
    tbl[19] = '{3'd7, 0, 0};
    t3r = '{3, 10, 3, 10, 3, 10, 3, 10, 3};
    t3c = '{0, 0, 1, 1, 2, 2, 3, 3, 4};
    ter = '{10, 0, 11, 0, 12, 0, 13};
    tec = '{14, 0, 14, 2, 14, 4, 14};
    t4r = '{14, 0, 14, 1, 14, 3, 14, 4, 12, 2};
    t4c = '{0, 14, 2, 13, 4, 11, 6, 10, 0, 12};

    cif.cmd_valid = 1'b0;
    cif.cmd       = CMD_NOP;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_state("reset");

    for (int i = 0; i < 20; i++) begin
      issue(tbl[i].cmd, "cursor vec");
      chk("cursor vec row", wide_t'(choose_row), wide_t'(tbl[i].row));
      chk("cursor vec col", wide_t'(choose_col), wide_t'(tbl[i].col));
    end

    issue(CMD_RESTART, "t2 restart");
    place_at(7, 7, "t2 place");
    chk("t2 bit112", wide_t'(display_black[112]), wide_t'(1'b1));
    chk("t2 turn", wide_t'(turn), wide_t'(1'b1));
    issue(CMD_PLACE, "t2 occupied");

    issue(CMD_RESTART, "t3 restart");
    for (int i = 0; i < 9; i++) place_at(t3r[i], t3c[i], "t3 place");
    chk("t3 over", wide_t'(game_over), wide_t'(1'b1));
    chk("t3 winner", wide_t'(winner), wide_t'(2'b01));
    issue(CMD_PLACE, "t3 frozen place");
    issue(CMD_UP, "t3 frozen up");
    issue(CMD_LEFT, "t3 frozen left");

    issue(CMD_RESTART, "edge restart");
    for (int i = 0; i < 7; i++) place_at(ter[i], tec[i], "edge place");
    chk("edge no win", wide_t'(game_over), wide_t'(1'b0));

    issue(CMD_RESTART, "t4 restart");
    for (int i = 0; i < 10; i++) place_at(t4r[i], t4c[i], "t4 place");
    chk("t4 winner", wide_t'(winner), wide_t'(2'b10));

    issue(CMD_RESTART, "t5 restart");
    do_cmd(CMD_PLACE);
    chk("t5 busy", wide_t'(busy), wide_t'(1'b1));
    do_cmd(CMD_UP);
    chk("t5 row while busy", wide_t'(choose_row), wide_t'(7));
    do_cmd(CMD_PLACE);
    chk("t5 reject while busy", wide_t'(reject), wide_t'(1'b0));
    do_cmd(CMD_LEFT);
    chk("t5 col while busy", wide_t'(choose_col), wide_t'(7));
    wait_idle();
    m_black[112] = 1'b1; m_count = 1; m_turn = 1'b1;
    chk_state("t5 after check");
    issue(CMD_RIGHT, "t5 move");
    do_cmd(CMD_PLACE);
    chk("t5 busy again", wide_t'(busy), wide_t'(1'b1));
    do_cmd(CMD_RESTART);
    model_reset();
    chk_state("t5 restart in busy");

    for (int rr = 0; rr < N; rr++)
      for (int cc = 0; cc < N; cc++)
        if ((cc + 2*rr) % 4 < 2) begin bl_r.push_back(rr); bl_c.push_back(cc); end
        else                     begin wh_r.push_back(rr); wh_c.push_back(cc); end
    for (int i = 0; i < bl_r.size(); i++) begin
      place_at(bl_r[i], bl_c[i], "t6 black");
      if (i < wh_r.size()) place_at(wh_r[i], wh_c[i], "t6 white");
    end
    chk("t6 over", wide_t'(game_over), wide_t'(1'b1));
    chk("t6 draw", wide_t'(winner), wide_t'(2'b11));

    issue(CMD_RESTART, "rand restart");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       rc = CMD_RESTART;
      else if (r < 40) rc = CMD_PLACE;
      else if (r < 46) rc = CMD_NOP;
      else             rc = 3'($urandom_range(1, 4));
      issue(rc, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
